// File: rtl/window_scan_if.sv
// Stream-side bundle of the window scan controller: beat enable in,
// line-buffer addresses, window strobe and window coordinates out.
interface window_scan_if #(
    parameter int FILTER_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int STRIDE_X     = 1,
    parameter int STRIDE_Y     = 1,
    parameter int CHANNELS     = 1
);
    localparam int DEPTH = (IMAGE_WIDTH - FILTER_SIZE + 1) * CHANNELS;
    localparam int OX_N  = (IMAGE_WIDTH - FILTER_SIZE) / STRIDE_X + 1;
    localparam int OY_N  = (IMAGE_HEIGHT - FILTER_SIZE) / STRIDE_Y + 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OXW   = (OX_N > 1) ? $clog2(OX_N) : 1;
    localparam int OYW   = (OY_N > 1) ? $clog2(OY_N) : 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic           clk_en;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;
    logic           valid;
    logic [OXW-1:0] out_x;
    logic [OYW-1:0] out_y;
    logic [CW-1:0]  out_ch;
    logic           frame_done;

    modport master (
        output clk_en,
        input  rd_addr, wr_addr, valid,
        input  out_x, out_y, out_ch, frame_done
    );

    modport slave (
        input  clk_en,
        output rd_addr, wr_addr, valid,
        output out_x, out_y, out_ch, frame_done
    );
endinterface

// File: rtl/window_scan_controller.sv
// Raster scan controller: circular line-buffer addressing plus a
// strided, channel-tagged window-valid strobe with frame wrap.
module window_scan_controller #(
    parameter int FILTER_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int STRIDE_X     = 1,
    parameter int STRIDE_Y     = 1,
    parameter int CHANNELS     = 1
) (
    input  logic         clk,
    input  logic         rst,
    window_scan_if.slave bus
);
    localparam int K     = FILTER_SIZE;
    localparam int W     = IMAGE_WIDTH;
    localparam int H     = IMAGE_HEIGHT;
    localparam int DEPTH = (W - K + 1) * CHANNELS;
    localparam int OX_N  = (W - K) / STRIDE_X + 1;
    localparam int OY_N  = (H - K) / STRIDE_Y + 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OXW   = (OX_N > 1) ? $clog2(OX_N) : 1;
    localparam int OYW   = (OY_N > 1) ? $clog2(OY_N) : 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW    = (W > 1) ? $clog2(W) : 1;
    localparam int YW    = (H > 1) ? $clog2(H) : 1;
    localparam int PXW   = (STRIDE_X > 1) ? $clog2(STRIDE_X) : 1;
    localparam int PYW   = (STRIDE_Y > 1) ? $clog2(STRIDE_Y) : 1;

    localparam logic [AW-1:0]  A_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  A_ONE   = AW'(1);
    localparam logic [AW-1:0]  RD_RST  = AW'((DEPTH > 1) ? 1 : 0);
    localparam logic [CW-1:0]  C_LAST  = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]  C_ONE   = CW'(1);
    localparam logic [XW-1:0]  X_LAST  = XW'(W - 1);
    localparam logic [XW-1:0]  X_EDGE  = XW'(K - 1);
    localparam logic [XW-1:0]  X_ONE   = XW'(1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(H - 1);
    localparam logic [YW-1:0]  Y_EDGE  = YW'(K - 1);
    localparam logic [YW-1:0]  Y_ONE   = YW'(1);
    localparam logic [PXW-1:0] PX_LAST = PXW'(STRIDE_X - 1);
    localparam logic [PXW-1:0] PX_ONE  = PXW'(1);
    localparam logic [PYW-1:0] PY_LAST = PYW'(STRIDE_Y - 1);
    localparam logic [PYW-1:0] PY_ONE  = PYW'(1);
    localparam logic [OXW-1:0] WX_ONE  = OXW'(1);
    localparam logic [OYW-1:0] WY_ONE  = OYW'(1);

    logic [CW-1:0]  ch;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [OXW-1:0] wx;
    logic [OYW-1:0] wy;

    logic [AW-1:0]  rd_q;
    logic [AW-1:0]  wr_q;
    logic           valid_q;
    logic [OXW-1:0] ox_q;
    logic [OYW-1:0] oy_q;
    logic [CW-1:0]  och_q;
    logic           done_q;

    logic pos_end;
    logic row_end;
    logic frm_end;
    logic x_in;
    logic y_in;
    logic col_ok;
    logic row_ok;
    logic qual;

    always_comb begin
        pos_end = (ch == C_LAST);
        row_end = pos_end && (x == X_LAST);
        frm_end = row_end && (y == Y_LAST);
        x_in    = (x >= X_EDGE);
        y_in    = (y >= Y_EDGE);
        col_ok  = x_in && (px == '0);
        row_ok  = y_in && (py == '0);
        qual    = col_ok && row_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= RD_RST;
            wr_q    <= '0;
            valid_q <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            och_q   <= '0;
            done_q  <= 1'b0;
            ch      <= '0;
            x       <= '0;
            y       <= '0;
            px      <= '0;
            py      <= '0;
            wx      <= '0;
            wy      <= '0;
        end else if (bus.clk_en) begin
            wr_q    <= (wr_q == A_LAST) ? '0 : wr_q + A_ONE;
            rd_q    <= (rd_q == A_LAST) ? '0 : rd_q + A_ONE;
            valid_q <= qual;
            done_q  <= frm_end;
            if (qual) begin
                ox_q  <= wx;
                oy_q  <= wy;
                och_q <= ch;
            end
            ch <= pos_end ? '0 : ch + C_ONE;
            // Column state advances once per pixel position
            if (pos_end) begin
                if (row_end) begin
                    x  <= '0;
                    px <= '0;
                    wx <= '0;
                end else begin
                    x <= x + X_ONE;
                    if (!x_in)
                        px <= '0;
                    else if (px == PX_LAST)
                        px <= '0;
                    else
                        px <= px + PX_ONE;
                    if (col_ok)
                        wx <= wx + WX_ONE;
                end
            end
            if (row_end) begin
                if (frm_end) begin
                    y  <= '0;
                    py <= '0;
                    wy <= '0;
                end else begin
                    y <= y + Y_ONE;
                    if (!y_in)
                        py <= '0;
                    else if (py == PY_LAST)
                        py <= '0;
                    else
                        py <= py + PY_ONE;
                    if (row_ok)
                        wy <= wy + WY_ONE;
                end
            end
        end else begin
            // Strobes are one-shot: a stalled cycle drops them
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

    assign bus.rd_addr    = rd_q;
    assign bus.wr_addr    = wr_q;
    assign bus.valid      = valid_q;
    assign bus.out_x      = ox_q;
    assign bus.out_y      = oy_q;
    assign bus.out_ch     = och_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_window_scan_controller.sv
// Scoreboard bench: three configurations of the scan controller
// checked beat by beat against a division-based raster model.
module tb_window_scan_controller;
    typedef struct {
        int v;
        int ox;
        int oy;
        int ch;
        int fd;
        int rd;
        int wr;
    } obs_t;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] en;

    int n_cmp;
    int n_bad;

    int cK[3]  = '{3, 3, 3};
    int cW[3]  = '{5, 6, 5};
    int cH[3]  = '{5, 6, 5};
    int cSX[3] = '{1, 2, 1};
    int cSY[3] = '{1, 2, 1};
    int cC[3]  = '{1, 1, 2};
    int cD[3]  = '{3, 4, 6};

    int m_n[3];
    int m_wr[3];
    int m_ox[3];
    int m_oy[3];
    int m_ch[3];
    int ovc[3];
    int ofd[3];

    obs_t sb[$];

    window_scan_if #(.FILTER_SIZE(3), .IMAGE_WIDTH(5),
        .IMAGE_HEIGHT(5), .STRIDE_X(1), .STRIDE_Y(1),
        .CHANNELS(1)) ifa ();
    window_scan_if #(.FILTER_SIZE(3), .IMAGE_WIDTH(6),
        .IMAGE_HEIGHT(6), .STRIDE_X(2), .STRIDE_Y(2),
        .CHANNELS(1)) ifb ();
    window_scan_if #(.FILTER_SIZE(3), .IMAGE_WIDTH(5),
        .IMAGE_HEIGHT(5), .STRIDE_X(1), .STRIDE_Y(1),
        .CHANNELS(2)) ifc ();

    assign ifa.clk_en = en[0];
    assign ifb.clk_en = en[1];
    assign ifc.clk_en = en[2];

    window_scan_controller #(.FILTER_SIZE(3), .IMAGE_WIDTH(5),
        .IMAGE_HEIGHT(5), .STRIDE_X(1), .STRIDE_Y(1),
        .CHANNELS(1)) u_a (.clk(clk), .rst(rst_v[0]), .bus(ifa.slave));
    window_scan_controller #(.FILTER_SIZE(3), .IMAGE_WIDTH(6),
        .IMAGE_HEIGHT(6), .STRIDE_X(2), .STRIDE_Y(2),
        .CHANNELS(1)) u_b (.clk(clk), .rst(rst_v[1]), .bus(ifb.slave));
    window_scan_controller #(.FILTER_SIZE(3), .IMAGE_WIDTH(5),
        .IMAGE_HEIGHT(5), .STRIDE_X(1), .STRIDE_Y(1),
        .CHANNELS(2)) u_c (.clk(clk), .rst(rst_v[2]), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        o = '{default: 0};
        case (d)
            0: begin
                o.v = int'(ifa.valid);  o.ox = int'(ifa.out_x);
                o.oy = int'(ifa.out_y); o.ch = int'(ifa.out_ch);
                o.fd = int'(ifa.frame_done);
                o.rd = int'(ifa.rd_addr); o.wr = int'(ifa.wr_addr);
            end
            1: begin
                o.v = int'(ifb.valid);  o.ox = int'(ifb.out_x);
                o.oy = int'(ifb.out_y); o.ch = int'(ifb.out_ch);
                o.fd = int'(ifb.frame_done);
                o.rd = int'(ifb.rd_addr); o.wr = int'(ifb.wr_addr);
            end
            default: begin
                o.v = int'(ifc.valid);  o.ox = int'(ifc.out_x);
                o.oy = int'(ifc.out_y); o.ch = int'(ifc.out_ch);
                o.fd = int'(ifc.frame_done);
                o.rd = int'(ifc.rd_addr); o.wr = int'(ifc.wr_addr);
            end
        endcase
        return o;
    endfunction

    function automatic void model_reset(input int d);
        m_n[d]  = 0;
        m_wr[d] = 0;
        m_ox[d] = 0;
        m_oy[d] = 0;
        m_ch[d] = 0;
    endfunction

    function automatic obs_t model_step(input int d, input bit acc);
        obs_t e;
        int b, c, pos, x, y, k;
        bit q;
        e = '{default: 0};
        k = cK[d];
        if (acc) begin
            b   = m_n[d];
            c   = b % cC[d];
            pos = b / cC[d];
            x   = pos % cW[d];
            y   = pos / cW[d];
            q   = (x >= k - 1) && (y >= k - 1) &&
                  ((x - k + 1) % cSX[d] == 0) &&
                  ((y - k + 1) % cSY[d] == 0);
            if (q) begin
                m_ox[d] = (x - k + 1) / cSX[d];
                m_oy[d] = (y - k + 1) / cSY[d];
                m_ch[d] = c;
            end
            e.v  = q ? 1 : 0;
            e.fd = (b == cW[d] * cH[d] * cC[d] - 1) ? 1 : 0;
            m_n[d]  = (b + 1) % (cW[d] * cH[d] * cC[d]);
            m_wr[d] = (m_wr[d] + 1) % cD[d];
        end
        e.ox = m_ox[d];
        e.oy = m_oy[d];
        e.ch = m_ch[d];
        e.wr = m_wr[d];
        e.rd = (m_wr[d] + 1) % cD[d];
        return e;
    endfunction

    task automatic compare(input int d, input obs_t o, input obs_t e);
        string p;
        p = $sformatf("d%0d.", d);
        check({p, "valid"}, o.v, e.v);
        check({p, "out_x"}, o.ox, e.ox);
        check({p, "out_y"}, o.oy, e.oy);
        check({p, "out_ch"}, o.ch, e.ch);
        check({p, "frame_done"}, o.fd, e.fd);
        check({p, "rd_addr"}, o.rd, e.rd);
        check({p, "wr_addr"}, o.wr, e.wr);
    endtask

    task automatic cycle(input int d, input bit acc);
        obs_t e;
        obs_t o;
        @(negedge clk);
        en = 3'b000;
        en[d] = acc;
        sb.push_back(model_step(d, acc));
        @(posedge clk);
        #1;
        o = observe(d);
        e = sb.pop_front();
        if (o.v != 0) ovc[d]++;
        if (o.fd != 0) ofd[d]++;
        compare(d, o, e);
    endtask

    task automatic run(input int d, input int nb, input int gap);
        int acc_n;
        int cyc;
        bit a;
        acc_n = 0;
        cyc   = 0;
        while (acc_n < nb && cyc < nb * 10 + 100) begin
            a = (gap == 0) || ($urandom_range(99) >= gap);
            cycle(d, a);
            if (a) acc_n++;
            cyc++;
        end
        check($sformatf("d%0d.beats_in_budget", d), acc_n, nb);
    endtask

    initial begin
        obs_t r;
        n_cmp = 0;
        n_bad = 0;
        en    = 3'b000;
        rst_v = 3'b111;
        for (int d = 0; d < 3; d++) begin
            model_reset(d);
            ovc[d] = 0;
            ofd[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            compare(d, observe(d), model_step(d, 1'b0));
        @(negedge clk);
        rst_v = 3'b000;

        run(0, 25, 0);
        check("a.frame1_valids", ovc[0], 9);
        check("a.frame1_done", ofd[0], 1);
        ovc[0] = 0;
        run(0, 25, 0);
        check("a.frame2_valids", ovc[0], 9);
        ovc[0] = 0;
        run(0, 25, 50);
        cycle(0, 1'b0);
        check("a.gapped_valids", ovc[0], 9);

        run(1, 36, 0);
        check("b.stride_valids", ovc[1], 4);
        run(2, 50, 0);
        check("c.chan_valids", ovc[2], 18);
        check("c.frame_done", ofd[2], 1);

        run(0, 17, 0);
        @(negedge clk);
        en = 3'b000;
        @(posedge clk);
        #3;
        rst_v[0] = 1'b1;
        #1;
        model_reset(0);
        r = model_step(0, 1'b0);
        compare(0, observe(0), r);
        @(negedge clk);
        rst_v[0] = 1'b0;
        ovc[0] = 0;
        run(0, 25, 0);
        check("a.post_reset_valids", ovc[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/window_scan_controller.md
Name: window_scan_controller

Overview:
Parametrised successor to the single-axis line buffer address/valid generator. Streams a raster image of IMAGE_WIDTH x IMAGE_HEIGHT positions, with CHANNELS interleaved beats per position. Generates circular line-buffer read/write addresses and a registered window-valid strobe with independent X/Y strides. Also tags each valid beat with output window coordinates and channel, and wraps cleanly at frame end. Sits between the pixel input stream and the convolution window registers.

Parameters:
FILTER_SIZE, 3, square window edge K (>=1, <=IMAGE_WIDTH, <=IMAGE_HEIGHT)
IMAGE_WIDTH, 28, pixels per row W
IMAGE_HEIGHT, 28, rows per frame H
STRIDE_X, 1, horizontal window step SX (>=1)
STRIDE_Y, 1, vertical window step SY (>=1)
CHANNELS, 1, beats per pixel position C (>=1)
(derived) DEPTH = (W-K+1)*C; AW = max(1,LOG2(DEPTH)); OXW/OYW/CW = max(1,LOG2) of (W-K)/SX+1, (H-K)/SY+1, C

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clk_en  in  1  one input beat accepted this cycle
rd_addr  out  AW  line-buffer read address
wr_addr  out  AW  line-buffer write address
valid  out  1  window complete at the beat accepted last cycle
out_x  out  OXW  output column index of valid window
out_y  out  OYW  output row index of valid window
out_ch  out  CW  channel of valid beat
frame_done  out  1  one-cycle pulse after last beat of frame

Behaviour:
- Reset (async assert, sync to clk on release): rd_addr=1 mod DEPTH (0 if DEPTH==1), wr_addr=0, valid=0, out_x=out_y=out_ch=0, frame_done=0, all internal counters (ch,x,y,stride phases) 0.
- State: ch in [0,C-1], x in [0,W-1], y in [0,H-1], phase_x in [0,SX-1], phase_y in [0,SY-1], window indices wx, wy.
- Only clk_en=1 cycles advance state; clk_en=0 freezes counters and addresses.
- Addresses: on each accepted beat rd_addr and wr_addr each increment, wrapping DEPTH-1 -> 0. rd_addr always = (wr_addr+1) mod DEPTH.
- Counters per beat: ch++; on ch==C-1, ch->0 and x++. On x==W-1 (with ch==C-1), x->0 and y++. On y==H-1 also, y->0; frame wraps.
- Stride phases: phase_x held 0 while x<K-1, else increments mod SX per position and resets at row start. phase_y behaves the same per row using y, and resets at frame start.
- Qualify: beat (ch,x,y) qualifies iff x>=K-1 && y>=K-1 && phase_x==0 && phase_y==0, evaluated on pre-update values.
- Output timing, latency 1: in the cycle after a qualifying accepted beat, valid=1, out_x=(x-(K-1))/SX, out_y=(y-(K-1))/SY, out_ch=ch.
- valid is a pulse: 0 in any cycle not directly following a qualifying accepted beat, including after clk_en=0 cycles. out_x/out_y/out_ch hold last values when valid=0.
- Indices: out_x/out_y come from incrementing wx/wy counters, not division. Trailing positions not stride-aligned (e.g. x=W-1 when (W-K)%SX!=0) never qualify.
- frame_done=1 in the cycle after the beat with ch==C-1, x==W-1, y==H-1; otherwise 0. It may coincide with valid for the last window.
- Address pointers do not reset at frame wrap. Only rst resets them.
- Mid-operation rst: all outputs go to reset values immediately, without waiting for clk. The next accepted beat is treated as (0,0,0) of a new frame.
- Boundary: K==W gives one window per qualifying row (out_x always 0). SX>W-K+1 behaves identically to SX=W-K+1.

Test Plan:
1. K=3, W=H=5, S=1, C=1, clk_en constant 1 -> first valid in cycle after 13th beat (x=2,y=2), out=(0,0). Exactly 9 valids per frame, rd_addr sequence 1,2,0,1..., frame_done after beat 25.
2. K=3, W=H=6, SX=SY=2, C=1 -> 4 valids per frame at (x,y)=(2,2),(4,2),(2,4),(4,4), out (0,0),(1,0),(0,1),(1,1). No valid at x=3,5 or y=3,5.
3. K=3, W=H=5, C=2 -> DEPTH=6, addresses wrap 5->0. Each window gives two consecutive valids with out_ch 0 then 1. 18 valids per frame; frame_done after beat 50.
4. Config 1 with random clk_en gaps (~50%) -> same valid/index/address sequence as case 1 per accepted beat. valid never high two cycles after a beat, and never high during a gap.
5. Config 1, 2 frames back-to-back -> second frame's valid pattern identical to first. Addresses continue without reset.
6. Config 1, assert rst at beat 17 asynchronously mid-cycle -> valid, addresses and indices take reset values immediately. Restart produces case 1's pattern from beat 0.
